// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_flags
// Description : Single-clock parametrised FIFO with fill-level count,
//               programmable almost-full / almost-empty thresholds and a
//               one-cycle error pulse on a rejected write or read.
//
//               Compile-time option FIFO_FWFT_EN selects first-word-fall-
//               through reads (head word visible on rdata_o while not
//               empty). Without it, rdata_o is registered and updates one
//               cycle after an accepted read.
//
// Ports       : clk_i          - single clock, rising edge
//               rst_i          - asynchronous active-high reset
//               wr_en_i        - write request
//               wdata_i        - write data (WIDTH)
//               rd_en_i        - read request
//               rdata_o        - read data (WIDTH)
//               full_o         - count == DEPTH
//               empty_o        - count == 0
//               almost_full_o  - count >= AF_LEVEL
//               almost_empty_o - count <= AE_LEVEL
//               count_o        - fill level 0..DEPTH (PTR_WIDTH+1)
//               error_o        - pulse after a rejected write or read
//
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4,
    parameter int AF_LEVEL  = 12,
    parameter int AE_LEVEL  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 rd_en_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o,
    output logic [PTR_WIDTH:0]   count_o,
    output logic                 error_o
);

    localparam logic [PTR_WIDTH:0]   c_depth     = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   c_af_level  = (PTR_WIDTH+1)'(AF_LEVEL);
    localparam logic [PTR_WIDTH:0]   c_ae_level  = (PTR_WIDTH+1)'(AE_LEVEL);
    localparam logic [PTR_WIDTH:0]   c_cnt_one   = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH:0]   c_cnt_zero  = '0;
    localparam logic [PTR_WIDTH-1:0] c_ptr_one   = (PTR_WIDTH)'(1);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;
    logic [PTR_WIDTH:0]   r_count;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_almost_full;
    logic                 r_almost_empty;
    logic                 r_error;

    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic [PTR_WIDTH:0]   w_count_nxt;

    // Acceptance uses the registered flags, i.e. the state before the edge.
    assign w_wr_acc = wr_en_i & ~r_full;
    assign w_rd_acc = rd_en_i & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + c_cnt_one;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - c_cnt_one;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    // Pointers wrap DEPTH-1 -> 0 through natural overflow (DEPTH = 2**PTR_WIDTH).
    // Flags are computed from the next count so they move with count_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_error        <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_depth);
            r_empty        <= (w_count_nxt == c_cnt_zero);
            r_almost_full  <= (w_count_nxt >= c_af_level);
            r_almost_empty <= (w_count_nxt <= c_ae_level);
            r_error        <= (wr_en_i & r_full) | (rd_en_i & r_empty);
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word falls through; value is meaningless while empty.
    assign rdata_o = r_mem[r_rd_ptr];
`else
    logic [WIDTH-1:0] r_rdata;

    // Registered read: holds the last popped word until the next accepted read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata <= '0;
        end else if (w_rd_acc) begin
            r_rdata <= r_mem[r_rd_ptr];
        end
    end

    assign rdata_o = r_rdata;
`endif

    assign full_o         = r_full;
    assign empty_o        = r_empty;
    assign almost_full_o  = r_almost_full;
    assign almost_empty_o = r_almost_empty;
    assign count_o        = r_count;
    assign error_o        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sync_fifo_flags
// Description : Self-checking bench for sync_fifo_flags (default parameters).
//               Table of fill/drain vectors plus hand-written sequences for
//               wrap, concurrent access, mid-stream reset and the read mode
//               selected by FIFO_FWFT_EN. Read data is checked against a
//               scoreboard queue of accepted writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_flags;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int PTR_WIDTH = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 wr_en_i;
    logic [WIDTH-1:0]     wdata_i;
    logic                 rd_en_i;
    logic [WIDTH-1:0]     rdata_o;
    logic                 full_o;
    logic                 empty_o;
    logic                 almost_full_o;
    logic                 almost_empty_o;
    logic [PTR_WIDTH:0]   count_o;
    logic                 error_o;

    sync_fifo_flags #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .PTR_WIDTH(PTR_WIDTH),
        .AF_LEVEL (12),
        .AE_LEVEL (4)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .wr_en_i       (wr_en_i),
        .wdata_i       (wdata_i),
        .rd_en_i       (rd_en_i),
        .rdata_o       (rdata_o),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .almost_full_o (almost_full_o),
        .almost_empty_o(almost_empty_o),
        .count_o       (count_o),
        .error_o       (error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic             wr;
        logic [WIDTH-1:0] wd;
        logic             rd;
        int               cnt;
        logic             full;
        logic             empty;
        logic             af;
        logic             ae;
        logic             err;
    } vec_t;

    vec_t             vecs[$];
    logic [WIDTH-1:0] sb_q[$];
    logic [WIDTH-1:0] m_rdata;
    logic             m_err;
    int               n_tests = 0;
    int               n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_rdata = '0;
        m_err   = 1'b0;
    endtask

    // Compare all outputs against the scoreboard-derived expectation.
    task automatic check_model(input string tag);
        int c;
        c = sb_q.size();
        check({tag, ".count"}, 32'(count_o), 32'(c));
        check({tag, ".empty"}, 32'(empty_o), 32'(c == 0));
        check({tag, ".full"},  32'(full_o),  32'(c == DEPTH));
        check({tag, ".af"},    32'(almost_full_o),  32'(c >= 12));
        check({tag, ".ae"},    32'(almost_empty_o), 32'(c <= 4));
        check({tag, ".error"}, 32'(error_o), 32'(m_err));
`ifdef FIFO_FWFT_EN
        if (c > 0) check({tag, ".rdata"}, 32'(rdata_o), 32'(sb_q[0]));
`else
        check({tag, ".rdata"}, 32'(rdata_o), 32'(m_rdata));
`endif
    endtask

    // One clock: drive at negedge, sample 1 ns after the rising edge.
    task automatic cycle(input logic wr, input logic [WIDTH-1:0] wd, input logic rd,
                         input string tag);
        bit wa, ra;
        @(negedge clk_i);
        wr_en_i = wr;
        wdata_i = wd;
        rd_en_i = rd;
        wa = wr && (sb_q.size() < DEPTH);
        ra = rd && (sb_q.size() > 0);
        @(posedge clk_i);
        #1;
        m_err = (wr && !wa) || (rd && !ra);
        if (ra) m_rdata = sb_q.pop_front();
        if (wa) sb_q.push_back(wd);
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        rst_i   = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        // ---------------- vector table: fill then drain ----------------
        for (int i = 0; i < 17; i++) begin
            vec_t v;
            int   c;
            c = (i + 1 > DEPTH) ? DEPTH : i + 1;
            v.wr = 1'b1; v.wd = WIDTH'(i + 1); v.rd = 1'b0;
            v.cnt = c; v.full = (c == DEPTH); v.empty = 1'b0;
            v.af = (c >= 12); v.ae = (c <= 4); v.err = (i == 16);
            vecs.push_back(v);
        end
        for (int i = 0; i < 18; i++) begin
            vec_t v;
            int   c;
            c = (15 - i < 0) ? 0 : 15 - i;
            v.wr = 1'b0; v.wd = '0; v.rd = 1'b1;
            v.cnt = c; v.full = 1'b0; v.empty = (c == 0);
            v.af = (c >= 12); v.ae = (c <= 4); v.err = (i >= 16);
            vecs.push_back(v);
        end

        // ---------------- reset state ----------------
        rst_i   = 1'b1;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        wdata_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset.empty", 32'(empty_o), 32'(1));
        check("reset.ae",    32'(almost_empty_o), 32'(1));
        check("reset.full",  32'(full_o), 32'(0));
        check("reset.af",    32'(almost_full_o), 32'(0));
        check("reset.count", 32'(count_o), 32'(0));
        check("reset.error", 32'(error_o), 32'(0));
`ifndef FIFO_FWFT_EN
        check("reset.rdata", 32'(rdata_o), 32'(0));
`endif
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();

        // ---------------- table-driven fill / drain ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cycle(vecs[i].wr, vecs[i].wd, vecs[i].rd, tag);
            check({tag, ".tcount"}, 32'(count_o), 32'(vecs[i].cnt));
            check({tag, ".tfull"},  32'(full_o),  32'(vecs[i].full));
            check({tag, ".tempty"}, 32'(empty_o), 32'(vecs[i].empty));
            check({tag, ".taf"},    32'(almost_full_o),  32'(vecs[i].af));
            check({tag, ".tae"},    32'(almost_empty_o), 32'(vecs[i].ae));
            check({tag, ".terr"},   32'(error_o), 32'(vecs[i].err));
        end
`ifndef FIFO_FWFT_EN
        check("drain.rdata_hold", 32'(rdata_o), 32'(8'h10));
`endif
        cycle(1'b0, '0, 1'b0, "idle_after_drain");

        // ---------------- pointer wrap ----------------
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, WIDTH'(8'h50 + i), 1'b0, "wrap.w1");
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, "wrap.r1");
        for (int i = 0; i < 10; i++) cycle(1'b1, WIDTH'(8'h20 + i), 1'b0, "wrap.w2");
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, "wrap.r2");
`ifndef FIFO_FWFT_EN
        check("wrap.last_rdata", 32'(rdata_o), 32'(8'h29));
`endif

        // ---------------- concurrent read/write ----------------
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, WIDTH'(8'h60 + i), 1'b0, "conc.fill");
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, WIDTH'(8'h70 + i), 1'b1, "conc.both");
            check("conc.count8", 32'(count_o), 32'(8));
            check("conc.noerr",  32'(error_o), 32'(0));
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, WIDTH'(8'h90 + i), 1'b0, "conc.tofull");
        check("conc.full", 32'(full_o), 32'(1));
        cycle(1'b1, 8'hEE, 1'b1, "conc.atfull");
        check("conc.atfull.count", 32'(count_o), 32'(15));
        check("conc.atfull.error", 32'(error_o), 32'(1));
        cycle(1'b0, '0, 1'b0, "conc.idle");

        // ---------------- simultaneous at empty ----------------
        do_reset();
        cycle(1'b1, 8'h3C, 1'b1, "empty_both");
        check("empty_both.count", 32'(count_o), 32'(1));
        check("empty_both.error", 32'(error_o), 32'(1));

        // ---------------- mid-stream asynchronous reset ----------------
        for (int i = 0; i < 4; i++) cycle(1'b1, WIDTH'(8'hB0 + i), 1'b0, "midrst.fill");
        @(negedge clk_i);
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        check("midrst.count", 32'(count_o), 32'(0));
        check("midrst.empty", 32'(empty_o), 32'(1));
        check("midrst.ae",    32'(almost_empty_o), 32'(1));
        check("midrst.full",  32'(full_o), 32'(0));
        check("midrst.af",    32'(almost_full_o), 32'(0));
        check("midrst.error", 32'(error_o), 32'(0));
`ifndef FIFO_FWFT_EN
        check("midrst.rdata", 32'(rdata_o), 32'(0));
`endif
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        cycle(1'b0, '0, 1'b0, "midrst.idle");

        // ---------------- single word: fall-through or registered ----------------
        cycle(1'b1, 8'hA5, 1'b0, "single.w");
`ifdef FIFO_FWFT_EN
        check("fwft.head", 32'(rdata_o), 32'(8'hA5));
        cycle(1'b0, '0, 1'b0, "single.hold");
        check("fwft.head_hold", 32'(rdata_o), 32'(8'hA5));
`endif
        cycle(1'b0, '0, 1'b1, "single.r");
        check("single.empty", 32'(empty_o), 32'(1));
`ifndef FIFO_FWFT_EN
        check("single.rdata", 32'(rdata_o), 32'(8'hA5));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
